full_adder: RTL and testbench
=============================

// Module: full_adder
// PURPOSE
//   Ripple-carry adder built from 1-bit full-adder cells: s = a + b + cin.
//   Default WIDTH=1 gives the classic 1-bit full adder.
//   Zero-latency combinational result, plus a registered copy with valid tag
//   for pipelined datapaths.
//   Leaf arithmetic cell used by wider adders/ALUs in the datapath.
// PARAMETERS
//   WIDTH  1  operand width in bits (>=1)
// PORTS
//   clk        in   1      rising-edge clock (registered path only)
//   rst_n      in   1      asynchronous active-low reset
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   cin        in   1      carry in
//   in_valid   in   1      qualifies a/b/cin for the registered path
//   s          out  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH
//   cout       out  1      combinational carry out, bit WIDTH of a+b+cin
//   s_q        out  WIDTH  registered sum
//   cout_q     out  1      registered carry out
//   out_valid  out  1      s_q/cout_q hold a result captured with in_valid=1
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous, active-low (rst_n).
//   - Bit cell i:
//       s[i]    = a[i]^b[i]^c[i]
//       c[i+1]  = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]
//       c[0]    = cin; cout = c[WIDTH]
//   - s/cout: purely combinational, zero latency.
//     Independent of clk, rst_n and in_valid.
//   - Any input change reflects on s/cout within the same delta/settle time.
//   - Registered path latency: 1 cycle.
//     On posedge clk with in_valid=1, capture {cout,s} into {cout_q,s_q}
//     and set out_valid=1.
//   - in_valid=0 at posedge: out_valid<=0; s_q/cout_q hold their previous value.
//   - Reset (rst_n=0, any time, including mid-operation):
//     s_q=0, cout_q=0, out_valid=0 immediately.
//     s/cout keep tracking inputs.
//   - Reset release: first capture occurs at the first posedge with rst_n=1.
//   - Overflow/wrap: all-ones + all-ones + 1 -> s=all-ones, cout=1.
//     No saturation.
//   - X on any input propagates to s/cout; no special handling.
// TESTING
//   - Exhaustive 1-bit: {a,b,cin}=0..7, one vector per 10 ns ->
//     (s,cout) = 00,10,10,01,10,01,01,11.
//   - WIDTH=1, a=1,b=1,cin=1 -> s=1,cout=1 combinationally with no clock running.
//   - Registered: in_valid=1, a=1,b=0,cin=1 at posedge ->
//     next cycle s_q=0,cout_q=1,out_valid=1.
//     in_valid=0 next edge -> out_valid=0, s_q/cout_q held.
//   - Assert rst_n=0 between clock edges with out_valid=1 ->
//     s_q,cout_q,out_valid go 0 without a clock edge; s/cout still correct.
//   - WIDTH=8: a=8'hFF,b=8'h01,cin=0 -> s=8'h00,cout=1.
//     a=8'hFF,b=8'hFF,cin=1 -> s=8'hFF,cout=1.
//   - WIDTH=8 random 1000 vectors vs a+b+cin reference model,
//     combinational and 1-cycle-delayed registered outputs.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder built from 1-bit full-adder cells.
//   s/cout      = a + b + cin, purely combinational (zero latency)
//   s_q/cout_q  = registered copy, captured on posedge clk when in_valid=1
//   out_valid   = 1 when s_q/cout_q hold a result captured with in_valid=1
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset (registered path)
//   a, b  [WIDTH]     unsigned operands
//   cin               carry in
//   in_valid          qualifies a/b/cin for the registered path
//   s [WIDTH], cout   combinational sum / carry out
//   s_q [WIDTH], cout_q, out_valid   registered result and valid tag

// One bit of the ripple chain.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             out_valid
);

    // Carry chain: c[0] is the external carry in, c[WIDTH] the carry out.
    logic [WIDTH:0] c;
    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c[i]),
            .s_o (s[i]),
            .c_o (c[i+1])
        );
    end

    assign cout = c[WIDTH];

    // Registered path: load on in_valid, otherwise hold the last result
    // while the valid tag drops.
    logic [WIDTH-1:0] s_d;
    logic             cout_d;

    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        if (in_valid) begin
            s_d    = s;
            cout_d = cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s_q       <= s_d;
            cout_q    <= cout_d;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk = 1'b0;
    logic run = 1'b0;
    logic rst_n = 1'b1;

    always #5 if (run) clk = ~clk;

    // 1-bit instance
    logic a1, b1, cin1, iv1;
    logic s1, co1, sq1, coq1, ov1;
    // 8-bit instance
    logic [7:0] a8, b8, s8, sq8;
    logic cin8, iv8, co8, coq8, ov8;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .s(s1), .cout(co1), .s_q(sq1), .cout_q(coq1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .s(s8), .cout(co8), .s_q(sq8), .cout_q(coq8), .out_valid(ov8)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer addition.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int unsigned t;
        t = int'(x) + int'(y) + int'(ci);
        return t[8:0];
    endfunction

    function automatic logic [1:0] ref1(input logic x, input logic y, input logic ci);
        int unsigned t;
        t = int'(x) + int'(y) + int'(ci);
        return t[1:0];
    endfunction

    // Expected register contents ({cout,s}) and valid flags.
    logic [8:0] exp_r8;
    logic [1:0] exp_r1;
    logic       exp_v8, exp_v1;

    initial begin
        logic [1:0] e1;
        logic [8:0] e8;
        logic [2:0] v;
        logic [1:0] tbl [8];
        tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b10; tbl[3] = 2'b01;
        tbl[4] = 2'b10; tbl[5] = 2'b01; tbl[6] = 2'b01; tbl[7] = 2'b11;

        a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
        a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;

        // Reset with no clock running
        #1 rst_n = 1'b0;
        #1;
        chk("rst_sq1", {30'd0, sq1, coq1}, 32'd0);
        chk("rst_ov1", {31'd0, ov1}, 32'd0);
        chk("rst_sq8", {23'd0, coq8, sq8}, 32'd0);
        chk("rst_ov8", {31'd0, ov8}, 32'd0);

        // Exhaustive 1-bit, combinational only, clock stopped; table is (s,cout)
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {a1, b1, cin1} = v;
            #10;
            chk($sformatf("exh1_%0d", i), {30'd0, s1, co1}, {30'd0, tbl[i]});
        end

        // 8-bit wrap boundaries
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; #1;
        chk("ff_01_0", {23'd0, co8, s8}, {23'd0, 9'h100});
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
        chk("ff_ff_1", {23'd0, co8, s8}, {23'd0, 9'h1FF});

        // Release reset between edges; first capture at first posedge
        a1 = 1; b1 = 0; cin1 = 1; iv1 = 1;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1; iv8 = 1;
        #3 rst_n = 1'b1;
        run = 1'b1;
        @(posedge clk); #1;
        chk("reg1_sq", {31'd0, sq1}, 32'd0);
        chk("reg1_coq", {31'd0, coq1}, 32'd1);
        chk("reg1_ov", {31'd0, ov1}, 32'd1);
        chk("reg8_first", {22'd0, ov8, coq8, sq8}, {22'd0, 1'b1, 9'h047});

        // in_valid=0: valid drops, data held
        @(negedge clk);
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        iv8 = 0; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        chk("hold1_ov", {31'd0, ov1}, 32'd0);
        chk("hold1_data", {30'd0, coq1, sq1}, 32'b10);
        chk("hold8_data", {22'd0, ov8, coq8, sq8}, {22'd0, 1'b0, 9'h047});

        // Capture again, then async reset mid-cycle
        @(negedge clk);
        iv1 = 1; a1 = 1; b1 = 1; cin1 = 1;
        iv8 = 1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1;
        @(posedge clk); #1;
        chk("pre_rst_ov8", {31'd0, ov8}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst1", {29'd0, ov1, coq1, sq1}, 32'd0);
        chk("async_rst8", {22'd0, ov8, coq8, sq8}, 32'd0);
        chk("comb_in_rst1", {30'd0, co1, s1}, 32'b11);
        chk("comb_in_rst8", {23'd0, co8, s8}, {23'd0, 9'h100});
        @(negedge clk);
        rst_n = 1'b1;
        iv1 = 0; iv8 = 0;
        @(posedge clk); #1;
        chk("post_rst_idle8", {22'd0, ov8, coq8, sq8}, 32'd0);

        exp_r8 = 9'd0; exp_r1 = 2'd0; exp_v8 = 0; exp_v1 = 0;

        // Randomized: comb vs reference, registered vs 1-cycle-delayed model
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            iv8 = ($urandom_range(0, 3) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            iv1 = ($urandom_range(0, 3) != 0);
            if (n % 8 == 0) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
            #1;
            e8 = ref8(a8, b8, cin8);
            e1 = ref1(a1, b1, cin1);
            chk("rnd_comb8", {23'd0, co8, s8}, {23'd0, e8});
            chk("rnd_comb1", {30'd0, co1, s1}, {30'd0, e1});
            if (iv8) exp_r8 = e8;
            if (iv1) exp_r1 = e1;
            exp_v8 = iv8; exp_v1 = iv1;
            @(posedge clk); #1;
            chk("rnd_reg8", {22'd0, ov8, coq8, sq8}, {22'd0, exp_v8, exp_r8});
            chk("rnd_reg1", {29'd0, ov1, coq1, sq1}, {29'd0, exp_v1, exp_r1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
